// File: rtl/pattern_bank_dbuf_pkg.sv
// Shared types and width helpers for the double-buffered pattern store.
// PATBUF_PARITY_EN adds one even-parity bit to every stored entry.
package patbuf_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      LOADED = 2'd2
   } patbuf_state_e;

`ifdef PATBUF_PARITY_EN
   localparam int PAR_W = 1;
`else
   localparam int PAR_W = 0;
`endif

   function automatic int patbuf_addr_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   function automatic int patbuf_cnt_w(input int depth, input int width);
      return $clog2(depth * width + 1);
   endfunction

endpackage

// File: rtl/pattern_bank_dbuf_if.sv
// Serial-load, swap handshake and field port bundle of the pattern store.
// master = PAT core / config side, slave = pattern_bank_dbuf.
interface pattern_bank_dbuf_if #(
   parameter int ADDR_W = 5,
   parameter int WIDTH  = 8
);
   logic              ssel;
   logic              sin;
   logic              sout;
   logic              load_done;
   logic              swap_req;
   logic              swap_ack;
   logic              active_bank;
   logic [ADDR_W-1:0] fieldp;
   logic [WIDTH-1:0]  field_byte;
   logic              field_write;
   logic [ADDR_W-1:0] fieldwp;
   logic [WIDTH-1:0]  field_in;
   logic              parity_err;

   modport master (
      output ssel, sin, swap_req, fieldp, field_write, fieldwp, field_in,
      input  sout, load_done, swap_ack, active_bank, field_byte, parity_err
   );

   modport slave (
      input  ssel, sin, swap_req, fieldp, field_write, fieldwp, field_in,
      output sout, load_done, swap_ack, active_bank, field_byte, parity_err
   );
endinterface

// File: rtl/pattern_bank_dbuf_bank.sv
// One pattern bank: serial shift chain through all entries plus a single write port.
// With PATBUF_PARITY_EN each entry carries parity, kept current on every shift.
module patbuf_bank
   import patbuf_pkg::*;
#(
   parameter int DEPTH = 32,
   parameter int WIDTH = 8,
   parameter int IDX_W = 5
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     shift_en,
   input  logic                     sin,
   input  logic                     wr_en,
   input  logic [IDX_W-1:0]         wr_addr,
   input  logic [WIDTH+PAR_W-1:0]   wr_data,
   input  logic [IDX_W-1:0]         rd_addr,
   output logic [WIDTH+PAR_W-1:0]   rd_data,
   output logic                     sout_bit
);

   localparam int EW = WIDTH + PAR_W;

   logic [EW-1:0]    mem [DEPTH];
   logic [WIDTH-1:0] shf [DEPTH];

   // Bit 0 of entry 0 takes sin; each entry's MSB feeds the next entry's LSB.
   assign shf[0] = {mem[0][WIDTH-2:0], sin};
   for (genvar i = 1; i < DEPTH; i++) begin : g_chain
      assign shf[i] = {mem[i][WIDTH-2:0], mem[i-1][WIDTH-1]};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (shift_en) begin
         for (int i = 0; i < DEPTH; i++) begin
`ifdef PATBUF_PARITY_EN
            mem[i] <= {^shf[i], shf[i]};
`else
            mem[i] <= shf[i];
`endif
         end
      end else if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data  = mem[rd_addr];
   assign sout_bit = mem[DEPTH-1][WIDTH-1];

endmodule

// File: rtl/pattern_bank_dbuf.sv
// Double-buffered pattern store: serial load into shadow, handshaked bank swap, field port on active.
// PATBUF_PARITY_EN enables per-entry even parity and the registered parity_err flag.
//
//   state  | meaning
//   IDLE   | no frame in progress (after reset or an accepted swap)
//   SHIFT  | partial frame in shadow, counting shifted bits
//   LOADED | full frame in shadow, swap may be accepted
module pattern_bank_dbuf
   import patbuf_pkg::*;
#(
   parameter int DEPTH  = 32,
   parameter int WIDTH  = 8,
   parameter int ADDR_W = patbuf_addr_w(DEPTH)
) (
   input logic                clk,
   input logic                rst_n,
   pattern_bank_dbuf_if.slave bus
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam int CNT_W = patbuf_cnt_w(DEPTH, WIDTH);
   localparam int EW    = WIDTH + PAR_W;

   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH * WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEPTH * WIDTH - 1);
   localparam logic [ADDR_W:0]  DEPTH_A  = (ADDR_W + 1)'(DEPTH);

   patbuf_state_e    state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             swap_go;
   logic             active_bank;
   logic             swap_ack;
   logic [WIDTH-1:0] field_byte;
   logic             wr_ok, rd_ok;
   logic [EW-1:0]    wr_word, rd0, rd1, rd_word;
   logic             sout0, sout1;

   // Addresses past DEPTH are legal on the bus: writes vanish, reads return zero.
   assign wr_ok = bus.field_write && ({1'b0, bus.fieldwp} < DEPTH_A);
   assign rd_ok = ({1'b0, bus.fieldp} < DEPTH_A);

`ifdef PATBUF_PARITY_EN
   assign wr_word = {^bus.field_in, bus.field_in};
`else
   assign wr_word = bus.field_in;
`endif

   patbuf_bank #(.DEPTH(DEPTH), .WIDTH(WIDTH), .IDX_W(IDX_W)) u_bank0 (
      .clk      (clk),
      .rst_n    (rst_n),
      .shift_en (bus.ssel & active_bank),
      .sin      (bus.sin),
      .wr_en    (wr_ok & ~active_bank),
      .wr_addr  (bus.fieldwp[IDX_W-1:0]),
      .wr_data  (wr_word),
      .rd_addr  (bus.fieldp[IDX_W-1:0]),
      .rd_data  (rd0),
      .sout_bit (sout0)
   );

   patbuf_bank #(.DEPTH(DEPTH), .WIDTH(WIDTH), .IDX_W(IDX_W)) u_bank1 (
      .clk      (clk),
      .rst_n    (rst_n),
      .shift_en (bus.ssel & ~active_bank),
      .sin      (bus.sin),
      .wr_en    (wr_ok & active_bank),
      .wr_addr  (bus.fieldwp[IDX_W-1:0]),
      .wr_data  (wr_word),
      .rd_addr  (bus.fieldp[IDX_W-1:0]),
      .rd_data  (rd1),
      .sout_bit (sout1)
   );

   assign rd_word = active_bank ? rd1 : rd0;

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      swap_go   = 1'b0;
      case (state)
         IDLE: begin
            if (bus.ssel) begin
               state_nxt = SHIFT;
               cnt_nxt   = CNT_ONE;
            end
         end
         SHIFT: begin
            if (bus.ssel) begin
               if (cnt == CNT_LAST) begin
                  state_nxt = LOADED;
                  cnt_nxt   = CNT_FULL;
               end else begin
                  cnt_nxt = cnt + CNT_ONE;
               end
            end
         end
         LOADED: begin
            // A new frame always beats a pending swap.
            if (bus.ssel) begin
               state_nxt = SHIFT;
               cnt_nxt   = CNT_ONE;
            end else if (bus.swap_req) begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
               swap_go   = 1'b1;
            end
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         cnt         <= '0;
         active_bank <= 1'b0;
         swap_ack    <= 1'b0;
         field_byte  <= '0;
      end else begin
         state       <= state_nxt;
         cnt         <= cnt_nxt;
         active_bank <= active_bank ^ swap_go;
         swap_ack    <= swap_go;
         field_byte  <= rd_ok ? rd_word[WIDTH-1:0] : '0;
      end
   end

`ifdef PATBUF_PARITY_EN
   logic parity_err;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) parity_err <= 1'b0;
      else        parity_err <= rd_ok & (^rd_word);
   end

   assign bus.parity_err = parity_err;
`else
   assign bus.parity_err = 1'b0;
`endif

   assign bus.sout        = active_bank ? sout0 : sout1;
   assign bus.load_done   = (state == LOADED);
   assign bus.swap_ack    = swap_ack;
   assign bus.active_bank = active_bank;
   assign bus.field_byte  = field_byte;

endmodule

// File: tb/tb_pattern_bank_dbuf.sv
// Directed bench for pattern_bank_dbuf at DEPTH=4, WIDTH=8 (ADDR_W=3 so out-of-range addresses exist).
// Parity-flip case is built only with PATBUF_PARITY_EN.
module tb_pattern_bank_dbuf;

   localparam int DEPTH  = 4;
   localparam int WIDTH  = 8;
   localparam int ADDR_W = 3;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_chk  = 0;
   int   n_fail = 0;

   pattern_bank_dbuf_if #(.ADDR_W(ADDR_W), .WIDTH(WIDTH)) bus ();

   pattern_bank_dbuf #(.DEPTH(DEPTH), .WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // Shifts n bits of w starting at bit msb, walking down.
   task automatic shift_bits(input logic [31:0] w, input int msb, input int n);
      for (int k = 0; k < n; k++) begin
         bus.ssel = 1'b1;
         bus.sin  = w[msb-k];
         tick();
      end
      bus.ssel = 1'b0;
      bus.sin  = 1'b0;
   endtask

   task automatic rd(input int addr, input logic [7:0] exp, input string tag);
      bus.fieldp = ADDR_W'(addr);
      tick();
      chk(tag, {24'h0, bus.field_byte}, {24'h0, exp});
   endtask

   // After a full 32-bit frame shifted MSB first, entry i holds w[8i+7:8i],
   // so the first byte of the word lands in the highest entry.
   logic [7:0] exp_b1 [DEPTH] = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};
   logic [7:0] exp_b0 [DEPTH] = '{8'h3C, 8'h2D, 8'h1E, 8'h0F};

   initial begin
      bus.ssel        = 1'b0;
      bus.sin         = 1'b0;
      bus.swap_req    = 1'b0;
      bus.fieldp      = '0;
      bus.field_write = 1'b0;
      bus.fieldwp     = '0;
      bus.field_in    = '0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // 1: fill shadow with ones, restart a frame, then reset mid-shift
      shift_bits(32'hFFFF_FFFF, 31, 32);
      chk("t1_load_done_full", bus.load_done, 1);
      chk("t1_sout_ones", bus.sout, 1);
      shift_bits(32'hFFFF_FFFF, 31, 3);
      chk("t1_load_done_restart", bus.load_done, 0);
      rst_n = 1'b0;
      #1;
      chk("rst_load_done", bus.load_done, 0);
      chk("rst_active_bank", bus.active_bank, 0);
      chk("rst_swap_ack", bus.swap_ack, 0);
      chk("rst_field_byte", bus.field_byte, 0);
      chk("rst_sout", bus.sout, 0);
      chk("rst_parity_err", bus.parity_err, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // 2: load 0xA1B2C3D4 into shadow while the active bank stays zero
      shift_bits(32'hA1B2_C3D4, 31, 31);
      chk("t2_not_done_31", bus.load_done, 0);
      shift_bits(32'hA1B2_C3D4, 0, 1);
      chk("t2_done_32", bus.load_done, 1);
      chk("t2_sout", bus.sout, 1);
      rd(0, 8'h00, "t2_old_active_0");
      rd(3, 8'h00, "t2_old_active_3");

      // 3: accepted swap
      bus.swap_req = 1'b1;
      tick();
      bus.swap_req = 1'b0;
      chk("t3_swap_ack", bus.swap_ack, 1);
      chk("t3_active_bank", bus.active_bank, 1);
      chk("t3_load_done_clr", bus.load_done, 0);
      tick();
      chk("t3_swap_ack_pulse", bus.swap_ack, 0);
      chk("t3_sout_new_shadow", bus.sout, 0);
      for (int i = 0; i < DEPTH; i++) rd(i, exp_b1[i], $sformatf("t3_read_%0d", i));
      rd(5, 8'h00, "t3_read_oob");

      // 4: swap ignored on a partial frame, and dropped when colliding with a shift
      shift_bits(32'h5566_7788, 31, 12);
      bus.swap_req = 1'b1;
      tick();
      bus.swap_req = 1'b0;
      chk("t4_partial_no_ack", bus.swap_ack, 0);
      chk("t4_partial_bank", bus.active_bank, 1);
      chk("t4_partial_not_done", bus.load_done, 0);
      shift_bits(32'h5566_7788, 19, 19);
      chk("t4_not_done_31", bus.load_done, 0);
      shift_bits(32'h5566_7788, 0, 1);
      chk("t4_done_32", bus.load_done, 1);
      rd(0, 8'hD4, "t4_active_intact");
      bus.ssel     = 1'b1;
      bus.sin      = 1'b0;
      bus.swap_req = 1'b1;
      tick();
      bus.swap_req = 1'b0;
      chk("t4_collide_no_ack", bus.swap_ack, 0);
      chk("t4_collide_bank", bus.active_bank, 1);
      chk("t4_collide_restart", bus.load_done, 0);
      shift_bits(32'h0F1E_2D3C, 30, 31);
      chk("t4_reload_done", bus.load_done, 1);
      bus.swap_req = 1'b1;
      tick();
      bus.swap_req = 1'b0;
      chk("t4_swap_ack", bus.swap_ack, 1);
      chk("t4_active_bank", bus.active_bank, 0);
      for (int i = 0; i < DEPTH; i++) rd(i, exp_b0[i], $sformatf("t4_read_%0d", i));

      // 5: field write, no bypass, out-of-range write discarded
      bus.field_write = 1'b1;
      bus.fieldwp     = 3'd2;
      bus.field_in    = 8'h5A;
      bus.fieldp      = 3'd2;
      tick();
      bus.field_write = 1'b0;
      chk("t5_no_bypass", bus.field_byte, 8'h1E);
      tick();
      chk("t5_written", bus.field_byte, 8'h5A);
      bus.field_write = 1'b1;
      bus.fieldwp     = 3'd4;
      bus.field_in    = 8'hFF;
      tick();
      bus.field_write = 1'b0;
      rd(0, 8'h3C, "t5_oob_e0");
      rd(1, 8'h2D, "t5_oob_e1");
      rd(2, 8'h5A, "t5_oob_e2");
      rd(3, 8'h0F, "t5_oob_e3");

      // write and read during the swap cycle both hit the bank that becomes shadow
      shift_bits(32'h0, 31, 32);
      chk("t5_zero_frame_done", bus.load_done, 1);
      bus.swap_req    = 1'b1;
      bus.field_write = 1'b1;
      bus.fieldwp     = 3'd1;
      bus.field_in    = 8'hF7;
      bus.fieldp      = 3'd1;
      tick();
      bus.swap_req    = 1'b0;
      bus.field_write = 1'b0;
      chk("t5_swap_cycle_read", bus.field_byte, 8'h2D);
      chk("t5_swap_cycle_bank", bus.active_bank, 1);
      rd(1, 8'h00, "t5_new_active_e1");
      // entry 1 of the new shadow reaches entry 3 after 16 shifts; its MSB then shows on sout
      shift_bits(32'h0, 31, 16);
      chk("t5_swap_write_landed", bus.sout, 1);

`ifdef PATBUF_PARITY_EN
      // 6: corrupt one stored bit of the active bank
      dut.u_bank1.mem[0][0] = ~dut.u_bank1.mem[0][0];
      bus.fieldp = 3'd0;
      tick();
      chk("t6_parity_err", bus.parity_err, 1);
      chk("t6_corrupt_data", bus.field_byte, 8'h01);
      bus.fieldp = 3'd1;
      tick();
      chk("t6_parity_clear", bus.parity_err, 0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
